// File: rtl/reg_banco_sb.sv
// Register file with two combinational read ports, one write port and a per-register load scoreboard.
// Latency: reads 0 cycles, writes/reservations visible after the edge; backpressure: none (decode stalls on busyA/busyB).
// Optional write-first forwarding on the read ports: define REG_BANCO_BYPASS_EN.
module reg_banco_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  input  logic [AW-1:0]    Rw,
  input  logic             WE_Reg,
  input  logic [WIDTH-1:0] dIN,
  input  logic [AW-1:0]    Rr,
  input  logic             RE_Res,
  output logic [WIDTH-1:0] doutA,
  output logic [WIDTH-1:0] doutB,
  output logic             busyA,
  output logic             busyB,
  output logic [AW:0]      pend_cnt
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_pend_cnt;

  logic             w_we_eff;
  logic             w_re_eff;
  logic             w_set;
  logic             w_clr;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_fwd_a;
  logic             w_fwd_b;

  assign w_we_eff = WE_Reg && !((ZERO_REG != 0) && (Rw == '0));
  assign w_re_eff = RE_Res && !((ZERO_REG != 0) && (Rr == '0));

  // Count moves only on real busy transitions; a same-address write+reserve nets to "stays/becomes busy".
  assign w_set = w_re_eff && !r_busy[Rr];
  assign w_clr = w_we_eff && r_busy[Rw] && !(w_re_eff && (Rr == Rw));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we_eff) w_busy_nxt[Rw] = 1'b0;
    if (w_re_eff) w_busy_nxt[Rr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_we_eff) begin
      r_regs[Rw] <= dIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= r_pend_cnt + (AW+1)'(w_set) - (AW+1)'(w_clr);
    end
  end

`ifdef REG_BANCO_BYPASS_EN
  assign w_fwd_a = rst_n && w_we_eff && (Ra == Rw);
  assign w_fwd_b = rst_n && w_we_eff && (Rb == Rw);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  always_comb begin
    doutA = r_regs[Ra];
    busyA = r_busy[Ra];
    if ((ZERO_REG != 0) && (Ra == '0)) begin
      doutA = '0;
      busyA = 1'b0;
    end
    if (w_fwd_a) begin
      doutA = dIN;
      busyA = 1'b0;
    end
  end

  always_comb begin
    doutB = r_regs[Rb];
    busyB = r_busy[Rb];
    if ((ZERO_REG != 0) && (Rb == '0)) begin
      doutB = '0;
      busyB = 1'b0;
    end
    if (w_fwd_b) begin
      doutB = dIN;
      busyB = 1'b0;
    end
  end

  assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_reg_banco_sb.sv
// Directed bench for reg_banco_sb (WIDTH=64, DEPTH=32, ZERO_REG=1): vector table plus hand sequences.
module tb_reg_banco_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Ra, Rb, Rw, Rr;
  logic        WE_Reg, RE_Res;
  logic [63:0] dIN;
  logic [63:0] doutA, doutB;
  logic        busyA, busyB;
  logic [5:0]  pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  reg_banco_sb #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE_Reg(WE_Reg), .dIN(dIN),
    .Rr(Rr), .RE_Res(RE_Res),
    .doutA(doutA), .doutB(doutB), .busyA(busyA), .busyB(busyB),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra, rb, rw;
    logic        we;
    logic [63:0] din;
    logic [4:0]  rr;
    logic        re;
    logic [63:0] ea, eb;
    logic        eba, ebb;
    logic [5:0]  ep;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one vector across a single edge, drop the enables, then check the stored state.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    Ra = v.ra; Rb = v.rb; Rw = v.rw; WE_Reg = v.we; dIN = v.din; Rr = v.rr; RE_Res = v.re;
    @(posedge clk);
    #1;
    WE_Reg = 1'b0; RE_Res = 1'b0;
    #1;
    chk($sformatf("v%0d doutA", idx), doutA, v.ea);
    chk($sformatf("v%0d doutB", idx), doutB, v.eb);
    chk($sformatf("v%0d busyA", idx), {63'd0, busyA}, {63'd0, v.eba});
    chk($sformatf("v%0d busyB", idx), {63'd0, busyB}, {63'd0, v.ebb});
    chk($sformatf("v%0d pend_cnt", idx), {58'd0, pend_cnt}, {58'd0, v.ep});
  endtask

  initial begin
    //           ra    rb    rw    we    din          rr    re    ea      eb      eba   ebb   ep
    vt[0]  = '{5'd1, 5'd0, 5'd1, 1'b1, 64'd5,      5'd0, 1'b0, 64'd5,  64'd0,  1'b0, 1'b0, 6'd0};
    vt[1]  = '{5'd1, 5'd7, 5'd7, 1'b1, 64'd12,     5'd0, 1'b0, 64'd5,  64'd12, 1'b0, 1'b0, 6'd0};
    vt[2]  = '{5'd0, 5'd7, 5'd0, 1'b1, 64'hFFFF,   5'd0, 1'b1, 64'd0,  64'd12, 1'b0, 1'b0, 6'd0};
    vt[3]  = '{5'd3, 5'd1, 5'd0, 1'b0, 64'd0,      5'd3, 1'b1, 64'd0,  64'd5,  1'b1, 1'b0, 6'd1};
    vt[4]  = '{5'd3, 5'd1, 5'd0, 1'b0, 64'd0,      5'd3, 1'b1, 64'd0,  64'd5,  1'b1, 1'b0, 6'd1};
    vt[5]  = '{5'd3, 5'd3, 5'd3, 1'b1, 64'd9,      5'd0, 1'b0, 64'd9,  64'd9,  1'b0, 1'b0, 6'd0};
    vt[6]  = '{5'd4, 5'd3, 5'd0, 1'b0, 64'd0,      5'd4, 1'b1, 64'd0,  64'd9,  1'b1, 1'b0, 6'd1};
    vt[7]  = '{5'd4, 5'd4, 5'd4, 1'b1, 64'd21,     5'd4, 1'b1, 64'd21, 64'd21, 1'b1, 1'b1, 6'd1};
    vt[8]  = '{5'd2, 5'd5, 5'd2, 1'b1, 64'd2,      5'd5, 1'b1, 64'd2,  64'd0,  1'b0, 1'b1, 6'd2};
    vt[9]  = '{5'd4, 5'd6, 5'd4, 1'b1, 64'd40,     5'd6, 1'b1, 64'd40, 64'd0,  1'b0, 1'b1, 6'd2};
    vt[10] = '{5'd9, 5'd5, 5'd9, 1'b1, 64'd77,     5'd0, 1'b0, 64'd77, 64'd0,  1'b0, 1'b1, 6'd2};
    vt[11] = '{5'd5, 5'd8, 5'd5, 1'b1, 64'd55,     5'd8, 1'b1, 64'd55, 64'd0,  1'b0, 1'b1, 6'd2};

    rst_n = 1'b0;
    Ra = '0; Rb = '0; Rw = '0; Rr = '0; WE_Reg = 1'b0; RE_Res = 1'b0; dIN = '0;
    #12;
    chk("reset doutA", doutA, 64'd0);
    chk("reset pend_cnt", {58'd0, pend_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(i, vt[i]);

    // Write to a busy register: reg 6 busy, old value 0, new value 33.
    @(negedge clk);
    Ra = 5'd6; Rb = 5'd6; Rw = 5'd6; WE_Reg = 1'b1; dIN = 64'd33;
    #1;
`ifdef REG_BANCO_BYPASS_EN
    chk("bypass pre doutA", doutA, 64'd33);
    chk("bypass pre doutB", doutB, 64'd33);
    chk("bypass pre busyA", {63'd0, busyA}, 64'd0);
`else
    chk("bypass pre doutA", doutA, 64'd0);
    chk("bypass pre doutB", doutB, 64'd0);
    chk("bypass pre busyA", {63'd0, busyA}, 64'd1);
`endif
    chk("bypass pre pend_cnt", {58'd0, pend_cnt}, 64'd2);
    @(posedge clk);
    #1;
    WE_Reg = 1'b0;
    #1;
    chk("bypass post doutA", doutA, 64'd33);
    chk("bypass post doutB", doutB, 64'd33);
    chk("bypass post busyA", {63'd0, busyA}, 64'd0);
    chk("bypass post pend_cnt", {58'd0, pend_cnt}, 64'd1);

    // Reservations are never forwarded.
    @(negedge clk);
    Ra = 5'd10; Rr = 5'd10; RE_Res = 1'b1;
    #1;
    chk("resv pre busyA", {63'd0, busyA}, 64'd0);
    @(posedge clk);
    #1;
    RE_Res = 1'b0;
    #1;
    chk("resv post busyA", {63'd0, busyA}, 64'd1);
    chk("resv post pend_cnt", {58'd0, pend_cnt}, 64'd2);

    // Reset mid-operation discards the pending write and reservation.
    @(negedge clk);
    Ra = 5'd6; Rb = 5'd10; Rw = 5'd11; WE_Reg = 1'b1; dIN = 64'd99; Rr = 5'd12; RE_Res = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst doutA", doutA, 64'd0);
    chk("midrst doutB", doutB, 64'd0);
    chk("midrst busyA", {63'd0, busyA}, 64'd0);
    chk("midrst busyB", {63'd0, busyB}, 64'd0);
    chk("midrst pend_cnt", {58'd0, pend_cnt}, 64'd0);
    @(negedge clk);
    WE_Reg = 1'b0; RE_Res = 1'b0;
    rst_n = 1'b1;
    Ra = 5'd11; Rb = 5'd12;
    #1;
    chk("postrst doutA", doutA, 64'd0);
    chk("postrst busyB", {63'd0, busyB}, 64'd0);
    apply(100, '{5'd11, 5'd12, 5'd11, 1'b1, 64'd99, 5'd12, 1'b1, 64'd99, 64'd0, 1'b0, 1'b1, 6'd1});

    // Reserve every address including 0: count saturates at DEPTH-1.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      Rr = 5'(i); RE_Res = 1'b1;
      @(posedge clk);
    end
    #1;
    RE_Res = 1'b0;
    Ra = 5'd31; Rb = 5'd0;
    #1;
    chk("full pend_cnt", {58'd0, pend_cnt}, 64'd31);
    chk("full busyA r31", {63'd0, busyA}, 64'd1);
    chk("full busyB r0", {63'd0, busyB}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_banco_sb.md
# reg_banco_sb

Parametrised successor of the 32x64 register bank: multi-width/multi-depth register file with two combinational read ports, one synchronous write port, and a per-register busy scoreboard tracking in-flight loads. Sits in the datapath between decode (read addresses, reservations) and write-back (Rw/dIN). Decode uses the scoreboard outputs to stall on read-after-load hazards.

## Interface
Parameters:
- WIDTH, 64, data width in bits (>=1)
- DEPTH, 32, number of registers (power of two, >=2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 1, when 1 register 0 reads as zero, and writes/reservations to it are ignored

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Ra  in  AW  read address, port A
- Rb  in  AW  read address, port B
- Rw  in  AW  write address
- WE_Reg  in  1  write enable
- dIN  in  WIDTH  write data
- Rr  in  AW  reservation address (destination of an issued load)
- RE_Res  in  1  reservation enable
- doutA  out  WIDTH  data of register Ra
- doutB  out  WIDTH  data of register Rb
- busyA  out  1  register Ra has a pending load
- busyB  out  1  register Rb has a pending load
- pend_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: DEPTH x WIDTH registers `regs`, DEPTH busy bits `busy`.
- Write: on rising clk with WE_Reg=1, regs[Rw] <= dIN and busy[Rw] <= 0. ZERO_REG=1 and Rw=0: no effect.
- Reserve: on rising clk with RE_Res=1, busy[Rr] <= 1. ZERO_REG=1 and Rr=0: ignored.
- Same edge, WE_Reg and RE_Res, Rw==Rr: data written, busy ends at 1 (new reservation wins).
- Reserve of an already-busy register: stays busy; pend_cnt unchanged.
- Write to a non-busy register: allowed, busy stays 0.
- Reads combinational: doutA = regs[Ra], doutB = regs[Rb]; busyA = busy[Ra], busyB = busy[Rb]. Address 0 with ZERO_REG=1 gives data 0, busy 0.
- pend_cnt: registered, equal to popcount(busy) after every edge. Net change per edge is -1, 0 or +1. Never exceeds DEPTH-ZERO_REG.

## Timing
- Reset (rst_n=0, any time, independent of clk): all regs=0, all busy=0, pend_cnt=0. doutA/doutB=0 and busyA/busyB=0 combinationally. Reset mid-operation discards any same-cycle write or reservation.
- First edge after rst_n rises performs normal updates.
- Write latency: data visible on doutA/doutB the cycle after the write edge, or the same cycle with bypass (see Configuration).
- Reservation latency: busyA/busyB asserted the cycle after the reserving edge. No same-cycle forwarding of reservations.
- Clear latency: busy cleared by the write edge.

## Configuration
- REG_BANCO_BYPASS_EN defined: write-first forwarding. When WE_Reg=1 and Ra==Rw (Rw≠0 if ZERO_REG), doutA=dIN and busyA=0 in the same cycle. Same for port B. Scoreboard state and pend_cnt are unaffected.
- Not defined: outputs reflect stored state only. New data and busy clear appear after the write edge.

## Test plan
- Reset: load regs, assert rst_n=0 between edges -> doutA=doutB=0, busyA=busyB=0, pend_cnt=0 immediately.
- Basic write/read: Rw=1, dIN=5, WE=1 for one edge; then Rw=7, dIN=12 -> Ra=1 gives 5, Rb=7 gives 12. Ra=0 gives 0 with ZERO_REG=1.
- Zero register: WE=1, Rw=0, dIN=0xFFFF, plus RE_Res=1, Rr=0 -> doutA(Ra=0)=0, busyA=0, pend_cnt=0.
- Scoreboard:
  - Reserve Rr=3 -> busyA(Ra=3)=1, pend_cnt=1.
  - Reserve Rr=3 again -> pend_cnt=1.
  - Write Rw=3, dIN=9 -> busyA=0, doutA=9, pend_cnt=0.
- Simultaneous: reg 4 busy; WE Rw=4 dIN=21 with RE_Res Rr=4 on one edge -> doutA=21, busyA=1, pend_cnt=1. Then WE Rw=2 with RE Rr=5 -> pend_cnt=2.
- Bypass: Ra=Rb=6, WE=1, Rw=6, dIN=33 before the edge -> with REG_BANCO_BYPASS_EN, doutA=doutB=33 pre-edge; without it, old value pre-edge and 33 post-edge.
